// File: rtl/viol_reset_ctrl.sv
// viol_reset_ctrl: turns monitor violation requests into a stretched core reset
// and keeps a small log (cause, episode count, violating PC) that survives it.
// Optional feature macro: VIOL_LOG_PC_EN (adds LAST_PC capture flops).
module viol_reset_ctrl #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [15:0] PER_BASE    = 16'h0190
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vrased_req,
  input  logic        casu_req,
  input  logic        garota_req,
  input  logic [15:0] pc,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  output logic [15:0] per_dout,
  output logic        cpu_rst,
  output logic        busy
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CAUSE_W = 3;
  localparam int unsigned DATA_W  = 16;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] REG_CAUSE  = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_LASTPC = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic               busy_q, busy_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  last_pc_rd;

  logic [CAUSE_W-1:0] req_bits;
  logic               req;
  logic               start;
  logic               sel;
  logic               wr;
  logic [1:0]         reg_idx;

  assign req_bits = {garota_req, casu_req, vrased_req};
  assign req      = |req_bits;

  // Window decode: 8-byte window, word index in the low two address bits
  assign sel     = per_en && ({1'b0, per_addr[13:2]} == PER_BASE[15:3]);
  assign wr      = sel && (|per_we);
  assign reg_idx = per_addr[1:0];

  // State, counter and output flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
    end
  end

  // Episode FSM: HOLD guarantees the minimum pulse, DRAIN waits for req to drop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    req_d   = req;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
          start   = 1'b1;
        end
      end
      ST_HOLD: begin
        // Leaving straight to IDLE when req is already gone keeps the pulse exact
        if (cnt_q == '0) begin
          state_d = req ? ST_DRAIN : ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        // req_q is the request as seen at the previous edge
        if (!req_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cpu_rst_d = (state_d != ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
  end

  // Log register flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q <= '0;
      count_q <= '0;
    end else begin
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  // Log updates: hardware set beats W1C, increment beats clear
  always_comb begin
    cause_d = cause_q;
    if (wr && (reg_idx == REG_CAUSE)) begin
      cause_d = cause_q & ~per_din[CAUSE_W-1:0];
    end
    cause_d = cause_d | req_bits;

    count_d = count_q;
    if (start) begin
      count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    end else if (wr && (reg_idx == REG_COUNT)) begin
      count_d = '0;
    end
  end

`ifdef VIOL_LOG_PC_EN
  logic [DATA_W-1:0] last_pc_q, last_pc_d;

  // Violating PC capture flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_pc_q <= '0;
    end else begin
      last_pc_q <= last_pc_d;
    end
  end

  // Capture PC only on the edge that opens an episode
  always_comb begin
    last_pc_d = last_pc_q;
    if (start) begin
      last_pc_d = pc;
    end
  end

  assign last_pc_rd = last_pc_q;

  logic unused_ok;
  assign unused_ok = ^per_din[DATA_W-1:CAUSE_W];
`else
  assign last_pc_rd = '0;

  logic unused_ok;
  assign unused_ok = ^{per_din[DATA_W-1:CAUSE_W], pc};
`endif

  // Combinational read mux, zero when not selected so it can be OR-ed on the bus
  always_comb begin
    per_dout = '0;
    if (sel) begin
      unique case (reg_idx)
        REG_CAUSE:  per_dout = DATA_W'(cause_q);
        REG_COUNT:  per_dout = DATA_W'(count_q);
        REG_LASTPC: per_dout = last_pc_rd;
        REG_STATUS: per_dout = DATA_W'(busy_q);
        default:    per_dout = '0;
      endcase
    end
  end

  assign cpu_rst = cpu_rst_q;
  assign busy    = busy_q;

endmodule
